// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
//
// Pulls bytes from an upstream FIFO that has one cycle of read latency and
// packs them little-endian into 32-bit words for a valid/ready consumer. The
// first byte read lands in word_out[7:0].
//
// Optional feature (macro PACK_TIMEOUT_EN):
//   When defined, a partial word (1..3 bytes) that has been idle for TIMEOUT
//   cycles with the FIFO empty is flushed with word_be marking the valid
//   lanes. When undefined, partial words wait for more data indefinitely and
//   every emitted word carries word_be = 4'hF.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset (highest priority)
//   clr          in   synchronous clear of accumulator, in-flight read and
//                     output register
//   fifo_dout    in   [7:0] FIFO read data, valid the cycle after fifo_re
//   fifo_empty   in   FIFO empty flag
//   fifo_re      out  FIFO read strobe, one byte popped per asserted cycle
//   word_out     out  [31:0] packed word (registered)
//   word_be      out  [3:0] byte enables, bit i covers word_out[8i+7:8i]
//   word_valid   out  word_out/word_be valid (registered)
//   word_ready   in   downstream accept
//
// Handshake: a word transfers on a rising edge where word_valid & word_ready.
// While word_valid & !word_ready, word_out/word_be/word_valid hold steady;
// word_valid never depends combinationally on word_ready.
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_re,
  output logic [31:0] word_out,
  output logic [3:0]  word_be,
  output logic        word_valid,
  input  logic        word_ready
);

  logic [31:0] acc_q, acc_d;
  logic [2:0]  acc_cnt_q, acc_cnt_d;
  logic        rd_pend_q, rd_pend_d;
  logic [31:0] word_out_q, word_out_d;
  logic [3:0]  word_be_q, word_be_d;
  logic        word_valid_q, word_valid_d;

  logic [2:0]  occupancy;
  logic        slot_free;

`ifdef PACK_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_d;
  logic          partial;
  logic          flush_go;
  logic [3:0]    partial_be;
`endif

  // Bytes already held plus the one in flight; a read is only issued when
  // the byte it returns is guaranteed a free lane, so nothing is dropped.
  assign occupancy = acc_cnt_q + {2'b00, rd_pend_q};
  assign fifo_re   = !fifo_empty && !clr && !rst && (occupancy < 3'd4);

  // Output register can take a new word now, or at this edge if the current
  // word is being accepted (allows back-to-back words).
  assign slot_free = !word_valid_q || word_ready;

`ifdef PACK_TIMEOUT_EN
  assign partial  = (acc_cnt_q != 3'd0) && (acc_cnt_q != 3'd4);
  // A capture in this cycle wins over a pending flush: packing continues.
  assign flush_go = partial && !rd_pend_q && (idle_q == IW'(TIMEOUT)) && slot_free;

  always_comb begin
    case (acc_cnt_q)
      3'd1:    partial_be = 4'h1;
      3'd2:    partial_be = 4'h3;
      3'd3:    partial_be = 4'h7;
      default: partial_be = 4'h0;
    endcase
  end
`endif

  always_comb begin
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    rd_pend_d    = fifo_re;
    word_out_d   = word_out_q;
    word_be_d    = word_be_q;
    word_valid_d = word_valid_q;
`ifdef PACK_TIMEOUT_EN
    idle_d       = idle_q;
`endif

    if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end

    // Capture the byte returned by last cycle's read. rd_pend_q implies
    // acc_cnt_q <= 3, so the low two bits select the lane.
    if (rd_pend_q) begin
      case (acc_cnt_q[1:0])
        2'd0:    acc_d[7:0]   = fifo_dout;
        2'd1:    acc_d[15:8]  = fifo_dout;
        2'd2:    acc_d[23:16] = fifo_dout;
        default: acc_d[31:24] = fifo_dout;
      endcase
      acc_cnt_d = acc_cnt_q + 3'd1;
    end

`ifdef PACK_TIMEOUT_EN
    if (rd_pend_q || !partial) begin
      idle_d = '0;
    end else if (fifo_empty && (idle_q != IW'(TIMEOUT))) begin
      idle_d = idle_q + IW'(1);
    end
`endif

    // A word completes either on the edge that captures its fourth byte or,
    // if the output was busy then, on the first edge the slot frees. The
    // accumulator is zeroed on load so unused lanes of a flushed partial
    // word read as zero.
    if ((acc_cnt_d == 3'd4) && slot_free) begin
      word_out_d   = acc_d;
      word_be_d    = 4'hF;
      word_valid_d = 1'b1;
      acc_d        = '0;
      acc_cnt_d    = '0;
    end
`ifdef PACK_TIMEOUT_EN
    else if (flush_go) begin
      word_out_d   = acc_q;
      word_be_d    = partial_be;
      word_valid_d = 1'b1;
      acc_d        = '0;
      acc_cnt_d    = '0;
      idle_d       = '0;
    end
`endif

    // Clear drops the in-flight byte as well: rd_pend is forced low so the
    // byte returning next cycle is never captured.
    if (clr) begin
      acc_d        = '0;
      acc_cnt_d    = '0;
      rd_pend_d    = 1'b0;
      word_out_d   = '0;
      word_be_d    = '0;
      word_valid_d = 1'b0;
`ifdef PACK_TIMEOUT_EN
      idle_d       = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      rd_pend_q    <= 1'b0;
      word_out_q   <= '0;
      word_be_q    <= '0;
      word_valid_q <= 1'b0;
`ifdef PACK_TIMEOUT_EN
      idle_q       <= '0;
`endif
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      rd_pend_q    <= rd_pend_d;
      word_out_q   <= word_out_d;
      word_be_q    <= word_be_d;
      word_valid_q <= word_valid_d;
`ifdef PACK_TIMEOUT_EN
      idle_q       <= idle_d;
`endif
    end
  end

  assign word_out   = word_out_q;
  assign word_be    = word_be_q;
  assign word_valid = word_valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
//
// Directed and random stimulus for fifo_rd_packer. A behavioural FIFO with
// one cycle of read latency feeds the DUT; bytes written to it are assembled
// into expected words on exp_q, which the monitor pops on each accepted word.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge or 1 unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clr;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_empty;
  logic        fifo_re;
  logic [31:0] word_out;
  logic [3:0]  word_be;
  logic        word_valid;
  logic        word_ready;

  fifo_rd_packer #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .word_out   (word_out),
    .word_be    (word_be),
    .word_valid (word_valid),
    .word_ready (word_ready)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- upstream FIFO model ----------------
  logic [7:0] fmem [0:2047];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       hold_empty;

  assign fifo_empty = (wr_ptr == rd_ptr) || hold_empty;

  always @(posedge clk) begin
    if (fifo_re) begin
      fifo_dout <= fmem[rd_ptr % 2048];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [3:0]  exp_be_q[$];
  logic [7:0]  asm_q[$];
  int          acc_cyc[$];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fifo_re) chk("re_while_empty", {31'b0, fifo_empty}, 32'd0);
    if (word_valid && word_ready) begin
      acc_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_word", word_out, 32'hDEAD_0000 ^ word_out ^ 32'hFFFF_FFFF);
      end else begin
        chk("word", word_out, exp_q.pop_front());
        chk("be", {28'b0, word_be}, {28'b0, exp_be_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_raw(input logic [7:0] b);
    fmem[wr_ptr % 2048] = b;
    wr_ptr++;
  endtask

  task automatic push_trk(input logic [7:0] b);
    push_raw(b);
    asm_q.push_back(b);
    if (asm_q.size() == 4) begin
      exp_q.push_back({asm_q[3], asm_q[2], asm_q[1], asm_q[0]});
      exp_be_q.push_back(4'hF);
      asm_q.delete();
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({tag, "_drain_left"}, exp_q.size(), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n_valid;
    rst        = 1'b1;
    clr        = 1'b0;
    hold_empty = 1'b1;
    word_ready = 1'b1;
    tick(3);
    chk("rst_valid", {31'b0, word_valid}, 32'd0);
    chk("rst_word", word_out, 32'd0);
    chk("rst_be", {28'b0, word_be}, 32'd0);
    chk("rst_re", {31'b0, fifo_re}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Preloaded FIFO, ready always high: two words five clocks apart.
    for (int i = 1; i <= 8; i++) push_trk(8'(i * 8'h11));
    acc_cyc.delete();
    hold_empty = 1'b0;
    drain("t_stream", 60);
    chk("t_stream_words", acc_cyc.size(), 32'd2);
    if (acc_cyc.size() >= 2) chk("t_stream_spacing", acc_cyc[1] - acc_cyc[0], 32'd5);

    // Backpressure: first word held, second packed and waiting, reads stop.
    word_ready = 1'b0;
    for (int i = 1; i <= 12; i++) push_trk(8'(i * 8'h11));
    acc_cyc.delete();
    tick(20);
    @(negedge clk);
    chk("bp_valid", {31'b0, word_valid}, 32'd1);
    chk("bp_word", word_out, 32'h44332211);
    chk("bp_be", {28'b0, word_be}, 32'hF);
    chk("bp_re", {31'b0, fifo_re}, 32'd0);
    tick(3);
    @(negedge clk);
    chk("bp_word_stable", word_out, 32'h44332211);
    chk("bp_re_stable", {31'b0, fifo_re}, 32'd0);
    @(posedge clk);
    #1;
    word_ready = 1'b1;
    drain("t_bp", 60);
    chk("t_bp_words", acc_cyc.size(), 32'd3);
    if (acc_cyc.size() >= 2) chk("t_bp_back2back", acc_cyc[1] - acc_cyc[0], 32'd1);

    // Reset mid-word: two bytes captured then discarded.
    push_raw(8'hE1);
    push_raw(8'hE2);
    tick(6);
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) push_trk(8'(i));
    @(negedge clk);
    chk("mid_rst_re", {31'b0, fifo_re}, 32'd0);
    tick(1);
    chk("mid_rst_valid", {31'b0, word_valid}, 32'd0);
    chk("mid_rst_word", word_out, 32'd0);
    chk("mid_rst_be", {28'b0, word_be}, 32'd0);
    rst = 1'b0;
    drain("t_rst", 60);

    // Partial word followed by a long idle period.
    push_raw(8'hA1);
    push_raw(8'hB2);
`ifdef PACK_TIMEOUT_EN
    exp_q.push_back(32'h0000B2A1);
    exp_be_q.push_back(4'h3);
    drain("t_timeout", 60);
`else
    n_valid = 0;
    repeat (100) begin
      @(negedge clk);
      if (word_valid) n_valid++;
    end
    chk("t_no_flush", n_valid, 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
`endif

    // clr the cycle after a read: the returning byte must be dropped.
    hold_empty = 1'b1;
    push_raw(8'h5A);
    tick(1);
    hold_empty = 1'b0;
    tick(1);
    clr        = 1'b1;
    hold_empty = 1'b1;
    tick(1);
    clr = 1'b0;
    @(negedge clk);
    chk("clr_valid", {31'b0, word_valid}, 32'd0);
    tick(1);
    for (int i = 1; i <= 4; i++) push_trk(8'(8'hC0 + i));
    hold_empty = 1'b0;
    drain("t_clr", 60);

    // Random data, FIFO toggling empty, random backpressure.
    for (int i = 0; i < 1000; i++) push_trk(8'($urandom_range(0, 255)));
    n_valid = 0;
    while (exp_q.size() != 0 && n_valid < 20000) begin
      @(posedge clk);
      #1;
      hold_empty = ~hold_empty;
      word_ready = ($urandom_range(0, 3) != 0);
      n_valid++;
    end
    chk("t_random_drain_left", exp_q.size(), 32'd0);
    hold_empty = 1'b1;
    word_ready = 1'b1;
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
